// File: rtl/morse_pkg.sv
// Shared constants, state encoding and slot-packing helper for the Morse encoder.
package morse_pkg;

  localparam int MAX_SYMBOLS = 5;
  localparam int CODE_W      = 10;

  localparam logic [1:0] SYM_EMPTY = 2'b00;
  localparam logic [1:0] SYM_DOT   = 2'b01;
  localparam logic [1:0] SYM_DASH  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_PRESS  = 2'b01,
    S_SHIFT  = 2'b10,
    S_COMMIT = 2'b11
  } state_t;

  // Slot 0 sits in the top two bits; target slot is known to be empty, so OR is enough.
  function automatic logic [CODE_W-1:0] place_symbol(input logic [CODE_W-1:0] word,
                                                      input logic [2:0]        slot,
                                                      input logic [1:0]        sym);
    logic [CODE_W-1:0] shifted;
    shifted = {sym, {(CODE_W-2){1'b0}}} >> (2 * slot);
    return word | shifted;
  endfunction

endpackage

// File: rtl/key_debouncer.sv
// Active-low push-button conditioner: 2-FF synchronizer, stability down-counter,
// registered press/release strobes. level is active-high (1 = held).
module key_debouncer #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clock,
  input  logic resetn,
  input  logic raw_n,
  output logic level,
  output logic press_edge,
  output logic release_edge
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] RELOAD = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_n;
  logic [CW-1:0] stable_cnt;
  logic          sample;

  assign sample = ~sync_n[1];

  // Bring the raw key into the clock domain; idle (released) is high.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) sync_n <= 2'b11;
    else         sync_n <= {sync_n[0], raw_n};
  end

  // Level flips only after DEBOUNCE_CYCLES consecutive differing samples.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      level        <= 1'b0;
      stable_cnt   <= RELOAD;
      press_edge   <= 1'b0;
      release_edge <= 1'b0;
    end else begin
      press_edge   <= 1'b0;
      release_edge <= 1'b0;
      if (sample == level) begin
        stable_cnt <= RELOAD;
      end else if (stable_cnt == '0) begin
        level        <= sample;
        stable_cnt   <= RELOAD;
        press_edge   <= sample;
        release_edge <= ~sample;
      end else begin
        stable_cnt <= stable_cnt - 1'b1;
      end
    end
  end

endmodule

// File: rtl/morse_encoder.sv
// Morse key capture: debounces the key and commit buttons, times presses in
// TICK_DIV-cycle ticks, packs up to five dot/dash symbols into a 10-bit word.
// Optional auto-commit after GAP_TICKS idle ticks: define MORSE_ENCODER_AUTOCOMMIT_EN.
//
// state    | meaning
// S_IDLE   | waiting for a key press or commit
// S_PRESS  | key held, counting ticks for dot/dash decision
// S_SHIFT  | writing the finished symbol into the working word
// S_COMMIT | code/code_valid presented; working word being cleared
module morse_encoder
  import morse_pkg::*;
#(
  parameter int TICK_DIV        = 25000000,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int DASH_TICKS      = 2
`ifdef MORSE_ENCODER_AUTOCOMMIT_EN
  , parameter int GAP_TICKS     = 4
`endif
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              key_n,
  input  logic              next_n,
  input  logic              enable,
  input  logic              clear,
  output logic [CODE_W-1:0] code,
  output logic              code_valid,
  output logic [CODE_W-1:0] live_code,
  output logic [2:0]        symbol_count,
  output logic              pressing,
  output logic              overflow
);

  localparam int TW = $clog2(TICK_DIV + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam int PW = $clog2(DASH_TICKS + 1);
  localparam logic [PW-1:0] DASH_LIM = PW'(DASH_TICKS);
  localparam logic [2:0] COUNT_FULL = 3'(MAX_SYMBOLS);
  localparam logic [CODE_W-1:0] WORD_EMPTY = {MAX_SYMBOLS{SYM_EMPTY}};

  logic key_level, key_press, key_release;
  logic next_level, next_press, next_release;
  logic next_unused;

  state_t            state, state_d;
  logic [TW-1:0]     tick_cnt;
  logic              tick;
  logic [PW-1:0]     press_ticks, ticks_d;
  logic [CODE_W-1:0] live_d, code_d;
  logic [2:0]        count_d;
  logic              ovf_d, valid_d;
  logic              gap_hit;

  key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_db (
    .clock(clock), .resetn(resetn), .raw_n(key_n),
    .level(key_level), .press_edge(key_press), .release_edge(key_release)
  );

  key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_next_db (
    .clock(clock), .resetn(resetn), .raw_n(next_n),
    .level(next_level), .press_edge(next_press), .release_edge(next_release)
  );

  assign next_unused = next_level ^ next_release;
  assign pressing    = key_level;
  assign tick        = (tick_cnt == TICK_LAST) && !key_press;

  // Timing tick; restarts on each key press so durations are measured from the press.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)                    tick_cnt <= '0;
    else if (key_press)             tick_cnt <= '0;
    else if (tick_cnt == TICK_LAST) tick_cnt <= '0;
    else                            tick_cnt <= tick_cnt + 1'b1;
  end

`ifdef MORSE_ENCODER_AUTOCOMMIT_EN
  localparam int GW = $clog2(GAP_TICKS + 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_TICKS - 1);
  logic [GW-1:0] gap_cnt, gap_d;

  // Idle-tick counter for auto-commit; only runs with a non-empty word in S_IDLE.
  always_comb begin
    gap_hit = 1'b0;
    gap_d   = gap_cnt;
    if (clear || state != S_IDLE || symbol_count == '0 || key_press) begin
      gap_d = '0;
    end else if (tick) begin
      if (gap_cnt == GAP_LAST) begin
        gap_hit = 1'b1;
        gap_d   = '0;
      end else begin
        gap_d = gap_cnt + 1'b1;
      end
    end
  end

  // Gap counter register.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) gap_cnt <= '0;
    else         gap_cnt <= gap_d;
  end
`else
  assign gap_hit = 1'b0;
`endif

  // Next-state and datapath: clear overrides everything; commit outranks key activity.
  always_comb begin
    state_d = state;
    live_d  = live_code;
    count_d = symbol_count;
    ovf_d   = overflow;
    code_d  = code;
    valid_d = 1'b0;
    ticks_d = press_ticks;
    if (clear) begin
      state_d = S_IDLE;
      live_d  = WORD_EMPTY;
      count_d = '0;
      ovf_d   = 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (next_press || gap_hit) begin
            state_d = S_COMMIT;
            code_d  = live_code;
            valid_d = 1'b1;
          end else if (key_press && enable) begin
            if (symbol_count == COUNT_FULL) begin
              ovf_d = 1'b1;
            end else begin
              ticks_d = '0;
              state_d = S_PRESS;
            end
          end
        end
        S_PRESS: begin
          if (next_press) begin
            state_d = S_COMMIT;
            code_d  = live_code;
            valid_d = 1'b1;
          end else if (!enable) begin
            state_d = S_IDLE;
          end else if (key_release) begin
            state_d = S_SHIFT;
          end else if (tick && press_ticks != DASH_LIM) begin
            ticks_d = press_ticks + 1'b1;
          end
        end
        S_SHIFT: begin
          live_d  = place_symbol(live_code, symbol_count,
                                 (press_ticks >= DASH_LIM) ? SYM_DASH : SYM_DOT);
          count_d = symbol_count + 3'd1;
          state_d = S_IDLE;
        end
        S_COMMIT: begin
          live_d  = WORD_EMPTY;
          count_d = '0;
          ovf_d   = 1'b0;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state        <= S_IDLE;
      live_code    <= '0;
      symbol_count <= '0;
      overflow     <= 1'b0;
      code         <= '0;
      code_valid   <= 1'b0;
      press_ticks  <= '0;
    end else begin
      state        <= state_d;
      live_code    <= live_d;
      symbol_count <= count_d;
      overflow     <= ovf_d;
      code         <= code_d;
      code_valid   <= valid_d;
      press_ticks  <= ticks_d;
    end
  end

endmodule

// File: tb/tb_morse_encoder.sv
// Scoreboarded bench for morse_encoder with short timing parameters.
// Builds with or without MORSE_ENCODER_AUTOCOMMIT_EN.
module tb_morse_encoder;

  logic       clock = 1'b0;
  logic       resetn;
  logic       key_n, next_n, enable, clear;
  logic [9:0] code, live_code;
  logic       code_valid, pressing, overflow;
  logic [2:0] symbol_count;

  int checks   = 0;
  int failures = 0;
  int pushes   = 0;
  int pulses   = 0;
  logic [9:0] sb[$];
  logic       prev_valid = 1'b0;

  morse_encoder #(
    .TICK_DIV(4),
    .DEBOUNCE_CYCLES(3),
    .DASH_TICKS(2)
`ifdef MORSE_ENCODER_AUTOCOMMIT_EN
    , .GAP_TICKS(4)
`endif
  ) dut (
    .clock(clock), .resetn(resetn), .key_n(key_n), .next_n(next_n),
    .enable(enable), .clear(clear), .code(code), .code_valid(code_valid),
    .live_code(live_code), .symbol_count(symbol_count),
    .pressing(pressing), .overflow(overflow)
  );

  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic press_key(input int hold, input int post);
    key_n = 1'b0; cyc(1);
    key_n = 1'b1; cyc(1);
    key_n = 1'b0; cyc(hold);
    key_n = 1'b1; cyc(post);
  endtask

  task automatic commit(input logic [9:0] exp);
    sb.push_back(exp);
    pushes++;
    next_n = 1'b0; cyc(6);
    next_n = 1'b1; cyc(10);
  endtask

  task automatic check_word(input string tag, input logic [9:0] w, input int cnt);
    check_val({tag, "_live"}, live_code, w);
    check_val({tag, "_count"}, symbol_count, cnt);
  endtask

  // Scoreboard: every valid pulse must match the oldest pending expectation.
  initial begin
    logic [9:0] exp;
    forever begin
      @(negedge clock);
      if (resetn && code_valid) begin
        pulses++;
        check_val("valid_width", prev_valid, 0);
        check_val("sb_pending", 32'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
          exp = sb.pop_front();
          check_val("code", code, exp);
        end
      end
      prev_valid = code_valid;
    end
  end

  initial begin
    resetn = 1'b0; key_n = 1'b1; next_n = 1'b1; enable = 1'b1; clear = 1'b0;
    cyc(3);
    check_val("rst_code", code, 0);
    check_val("rst_valid", code_valid, 0);
    check_val("rst_live", live_code, 0);
    check_val("rst_count", symbol_count, 0);
    check_val("rst_pressing", pressing, 0);
    check_val("rst_overflow", overflow, 0);
    resetn = 1'b1;
    cyc(2);

    // Bounced short press becomes a dot in slot 0.
    press_key(6, 10);
    check_word("dot", 10'b01_00000000, 1);
    check_val("dot_pressing", pressing, 0);

    // Long press becomes a dash in slot 1; commit the pair.
    press_key(12, 10);
    check_word("dash", 10'b01_11_000000, 2);
    commit(10'b01_11_000000);
    check_word("after_commit", 10'b0, 0);

    // Commit of an empty word still pulses with code 0.
    commit(10'b0);
    check_word("empty_commit", 10'b0, 0);

    // Fill all five slots, then a sixth press only sets overflow.
    for (int i = 0; i < 5; i++) press_key(6, 10);
    check_word("full", 10'b01_01_01_01_01, 5);
    check_val("full_overflow", overflow, 0);
    press_key(6, 2);
    check_word("sixth", 10'b01_01_01_01_01, 5);
    check_val("sixth_overflow", overflow, 1);
    commit(10'b01_01_01_01_01);
    check_val("commit_overflow", overflow, 0);
    check_word("after_full", 10'b0, 0);

    // Commit while a key is held drops the held symbol; its release writes nothing.
    press_key(6, 10);
    key_n = 1'b0; cyc(12);
    check_val("held_pressing", pressing, 1);
    sb.push_back(10'b01_00000000);
    pushes++;
    next_n = 1'b0; cyc(6);
    next_n = 1'b1; cyc(4);
    key_n = 1'b1; cyc(10);
    check_word("held_release", 10'b0, 0);

    // Clear overlapping a next edge: no pulse, code kept, word emptied.
    press_key(6, 10);
    check_word("pre_clear", 10'b01_00000000, 1);
    clear = 1'b1; next_n = 1'b0; cyc(8);
    clear = 1'b0; cyc(2);
    next_n = 1'b1; cyc(10);
    check_val("clear_code", code, 10'b01_00000000);
    check_word("clear", 10'b0, 0);

`ifdef MORSE_ENCODER_AUTOCOMMIT_EN
    // One dot then silence commits by itself; an empty word never does.
    sb.push_back(10'b01_00000000);
    pushes++;
    press_key(6, 10);
    cyc(30);
    check_word("auto", 10'b0, 0);
    cyc(30);
`endif

    // Reset in the middle of a press returns everything to zero.
    key_n = 1'b0; cyc(8);
    resetn = 1'b0; cyc(1);
    check_val("midrst_code", code, 0);
    check_val("midrst_pressing", pressing, 0);
    check_val("midrst_valid", code_valid, 0);
    key_n = 1'b1; cyc(2);
    resetn = 1'b1; cyc(10);
    check_word("post_rst", 10'b0, 0);

    cyc(5);
    check_val("sb_drain", sb.size(), 0);
    check_val("pulse_count", pulses, pushes);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
